// File: rtl/selector_rr.sv
// selector_rr: CH-to-1 registered valid/ready selector, fixed-SEL or round-robin; SELECTOR_PARITY_EN adds y_par_o
module selector_rr #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH*WIDTH-1:0] din_i,
  input  logic [CH-1:0]     valid_i,
  output logic [CH-1:0]     ready_o,
  input  logic              mode_i,
  input  logic [SELW-1:0]   sel_i,
  output logic [WIDTH-1:0]  y_o,
  output logic              y_valid_o,
  input  logic              y_ready_i,
`ifdef SELECTOR_PARITY_EN
  output logic              y_par_o,
`endif
  output logic [SELW-1:0]   y_ch_o
);
  logic              y_valid_q, y_valid_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [SELW-1:0]   y_ch_q, y_ch_d, ptr_q, ptr_d, gnt;
  logic              gnt_vld, load, xfer;
  logic [WIDTH-1:0]  gnt_data;
  // descending scan so the channel nearest ptr_q wins last
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    if (mode_i) begin
      for (int k = CH - 1; k >= 0; k--) begin
        if (valid_i[(int'(ptr_q) + k) % CH]) begin
          gnt = SELW'((int'(ptr_q) + k) % CH);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      gnt = sel_i;
      for (int i = 0; i < CH; i++)
        if (sel_i == SELW'(i) && valid_i[i]) gnt_vld = 1'b1;
    end
  end
  assign gnt_data = din_i[int'(gnt)*WIDTH +: WIDTH];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_valid_q <= 1'b0;
      y_q <= '0;
      y_ch_q <= '0;
      ptr_q <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_q <= y_d;
      y_ch_q <= y_ch_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    load = !y_valid_q || y_ready_i;
    xfer = load && gnt_vld && !rst_i;
    y_valid_d = xfer || (y_valid_q && !y_ready_i);
    y_d = xfer ? gnt_data : y_q;
    y_ch_d = xfer ? gnt : y_ch_q;
    ptr_d = (mode_i && xfer) ? ((gnt == SELW'(CH - 1)) ? '0 : gnt + SELW'(1)) : ptr_q;
  end
  always_comb begin
    ready_o = xfer ? (CH'(1) << gnt) : '0;
    y_o = y_q;
    y_valid_o = y_valid_q;
    y_ch_o = y_ch_q;
  end
`ifdef SELECTOR_PARITY_EN
  logic y_par_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) y_par_q <= 1'b0;
    else if (xfer) y_par_q <= ^gnt_data;
  end
  assign y_par_o = y_par_q;
`endif
endmodule

// File: tb/tb_selector_rr.sv
// tb_selector_rr: vector table, corner sequences and randomized model check for selector_rr
module tb_selector_rr;
  localparam int W = 8;
  localparam int CH = 4;
  logic clk = 1'b0;
  logic rst;
  logic [CH*W-1:0] din;
  logic [CH-1:0] valid, ready;
  logic mode, y_valid, y_ready;
  logic [1:0] sel, y_ch;
  logic [W-1:0] y;
  logic [3*W-1:0] din3;
  logic [2:0] valid3, ready3;
  logic [1:0] sel3, y_ch3;
  logic [W-1:0] y3;
  logic y_valid3;
`ifdef SELECTOR_PARITY_EN
  logic y_par, y_par3;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  selector_rr #(.WIDTH(W), .CH(CH)) u_dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .valid_i(valid), .ready_o(ready),
    .mode_i(mode), .sel_i(sel), .y_o(y), .y_valid_o(y_valid), .y_ready_i(y_ready),
`ifdef SELECTOR_PARITY_EN
    .y_par_o(y_par),
`endif
    .y_ch_o(y_ch));

  selector_rr #(.WIDTH(W), .CH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .din_i(din3), .valid_i(valid3), .ready_o(ready3),
    .mode_i(1'b0), .sel_i(sel3), .y_o(y3), .y_valid_o(y_valid3), .y_ready_i(1'b1),
`ifdef SELECTOR_PARITY_EN
    .y_par_o(y_par3),
`endif
    .y_ch_o(y_ch3));

  typedef struct {
    logic mode; logic [1:0] sel; logic [3:0] valid; logic [31:0] din; logic yr;
    logic [3:0] exp_ready; logic [7:0] exp_y; logic exp_yv; logic [1:0] exp_ch;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic m, input int s, input logic [3:0] v, input int p);
    if (!m) return (s < CH && v[s]) ? s : -1;
    for (int k = 0; k < CH; k++)
      if (v[(p + k) % CH]) return (p + k) % CH;
    return -1;
  endfunction

  int m_ptr, g;
  logic [7:0] m_y;
  logic m_yv, m_par;
  logic [1:0] m_ch;
  logic [3:0] exp_rdy;

  initial begin
    vt[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00AA0000, 1'b0, 4'b0100, 8'hAA, 1'b1, 2'd2};
    vt[1]  = '{1'b0, 2'd2, 4'b0100, 32'h00550000, 1'b0, 4'b0000, 8'hAA, 1'b1, 2'd2};
    vt[2]  = '{1'b0, 2'd2, 4'b0100, 32'h00550000, 1'b1, 4'b0100, 8'h55, 1'b1, 2'd2};
    vt[3]  = '{1'b0, 2'd2, 4'b0000, 32'h00550000, 1'b1, 4'b0000, 8'h55, 1'b0, 2'd2};
    vt[4]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 1'b1, 2'd0};
    vt[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 1'b1, 2'd1};
    vt[6]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 8'h12, 1'b1, 2'd2};
    vt[7]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 8'h13, 1'b1, 2'd3};
    vt[8]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 1'b1, 2'd0};
    vt[9]  = '{1'b1, 2'd0, 4'b0100, 32'h13121110, 1'b1, 4'b0100, 8'h12, 1'b1, 2'd2};
    vt[10] = '{1'b1, 2'd0, 4'b0010, 32'h13121110, 1'b1, 4'b0010, 8'h11, 1'b1, 2'd1};
    vt[11] = '{1'b1, 2'd0, 4'b1001, 32'h13121110, 1'b1, 4'b1000, 8'h13, 1'b1, 2'd3};
    vt[12] = '{1'b1, 2'd0, 4'b1001, 32'h13121110, 1'b1, 4'b0001, 8'h10, 1'b1, 2'd0};
    vt[13] = '{1'b1, 2'd0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 8'h10, 1'b0, 2'd0};

    rst = 1'b1; valid = '1; din = '0; mode = 1'b0; sel = '0; y_ready = 1'b0;
    din3 = '0; valid3 = '1; sel3 = 2'd3;
    step();
    step();
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_yv", 32'(y_valid), 32'h0);
    chk("reset_ych", 32'(y_ch), 32'h0);
    valid = '0;
    rst = 1'b0;
    step();

    foreach (vt[i]) begin
      mode = vt[i].mode; sel = vt[i].sel; valid = vt[i].valid; din = vt[i].din; y_ready = vt[i].yr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vt[i].exp_ready));
      step();
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vt[i].exp_y));
      chk($sformatf("vec%0d_yv", i), 32'(y_valid), 32'(vt[i].exp_yv));
      chk($sformatf("vec%0d_ych", i), 32'(y_ch), 32'(vt[i].exp_ch));
    end

    // CH=3 with SEL=3 never grants
    #1;
    chk("ch3_sel3_ready", 32'(ready3), 32'h0);
    step();
    chk("ch3_sel3_yv", 32'(y_valid3), 32'h0);

    // reset while FULL discards the word
    mode = 1'b0; sel = 2'd2; valid = 4'b0100; din = 32'h00AA0000; y_ready = 1'b0;
    step();
    chk("full_before_rst_y", 32'(y), 32'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0; valid = '0;
    chk("midrst_yv", 32'(y_valid), 32'h0);
    chk("midrst_y", 32'(y), 32'h0);
    chk("midrst_ych", 32'(y_ch), 32'h0);

`ifdef SELECTOR_PARITY_EN
    chk("par_reset", 32'(y_par), 32'h0);
    sel = 2'd0; valid = 4'b0001; y_ready = 1'b1; din = 32'h00000007;
    step();
    chk("par_07", 32'(y_par), 32'h1);
    din = 32'h00000003;
    step();
    chk("par_03", 32'(y_par), 32'h0);
    valid = '0;
    step();
    chk("par_hold", 32'(y_par), 32'h0);
`endif

    // randomized run against a scoreboard model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0; m_y = '0; m_yv = 1'b0; m_ch = '0; m_par = 1'b0;
    for (int n = 0; n < 400; n++) begin
      mode = 1'($urandom); sel = 2'($urandom); valid = 4'($urandom);
      din = $urandom; y_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      #1;
      g = (!m_yv || y_ready) && !rst ? pick(mode, int'(sel), valid, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      chk("rand_ready", 32'(ready), 32'(exp_rdy));
      if (rst) begin
        m_ptr = 0; m_y = '0; m_yv = 1'b0; m_ch = '0; m_par = 1'b0;
      end else if (g >= 0) begin
        m_y = din[g*8 +: 8]; m_ch = 2'(g); m_yv = 1'b1; m_par = ^din[g*8 +: 8];
        if (mode) m_ptr = (g + 1) % CH;
      end else if (y_ready) m_yv = 1'b0;
      step();
      chk("rand_y", 32'(y), 32'(m_y));
      chk("rand_yv", 32'(y_valid), 32'(m_yv));
      chk("rand_ych", 32'(y_ch), 32'(m_ch));
`ifdef SELECTOR_PARITY_EN
      chk("rand_par", 32'(y_par), 32'(m_par));
`endif
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
